// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester and dmem signal bundle for dmem_port_arbiter
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // port 0: processor data path
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  // port 1: game/display engine
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  // dmem syncram side
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  // requesters plus the dmem instance
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_address, mem_data, mem_wren,
    output mem_q
  );

  // the arbiter
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_address, mem_data, mem_wren,
    input  mem_q
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin two-port arbiter in front of the single-port dmem
module dmem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic           clock,
  input logic           reset,
  dmem_port_arbiter_if.slave bus
);

  // pointer names the port that wins when both request
  typedef enum logic {RR_P0 = 1'b0, RR_P1 = 1'b1} rr_t;

  rr_t               rr_q;
  rr_t               rr_d;
  logic              gnt0;
  logic              gnt1;
  logic              rd_new;
  logic              wr_new;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wren_q;

  // read tags: stage i is valid in cycle N+1+i for a read granted in cycle N
  logic [RD_LAT:0]   tag_vld;
  logic [RD_LAT:0]   tag_own;

  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // arbitration and pointer next state; grants are held off while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    rr_d = rr_q;
    if (reset) begin
      if (bus.p0_req && (!bus.p1_req || rr_q == RR_P0)) begin
        gnt0 = 1'b1;
      end else if (bus.p1_req) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      rr_d = RR_P1;
    end else if (gnt1) begin
      rr_d = RR_P0;
    end
  end

  // command of the granted port
  always_comb begin
    sel_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    wr_new    = (gnt0 && bus.p0_we) || (gnt1 && bus.p1_we);
    rd_new    = (gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we);
  end

  // pointer register and registered dmem command; address/data hold on idle cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q          <= RR_P0;
      mem_wren_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
    end else begin
      rr_q       <= rr_d;
      mem_wren_q <= wr_new;
      if (gnt0 || gnt1) begin
        mem_address_q <= sel_addr;
        mem_data_q    <= sel_wdata;
      end
    end
  end

  // owner tag pipe, aligned with mem_q latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld <= {tag_vld[RD_LAT-1:0], rd_new};
      tag_own <= {tag_own[RD_LAT-1:0], gnt1};
    end
  end

  // capture mem_q for the owning port; rdata holds between reads
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= tag_vld[RD_LAT] && !tag_own[RD_LAT];
      rvalid1_q <= tag_vld[RD_LAT] &&  tag_own[RD_LAT];
      if (tag_vld[RD_LAT] && !tag_own[RD_LAT]) begin
        rdata0_q <= bus.mem_q;
      end
      if (tag_vld[RD_LAT] && tag_own[RD_LAT]) begin
        rdata1_q <= bus.mem_q;
      end
    end
  end

  assign bus.p0_gnt      = gnt0;
  assign bus.p1_gnt      = gnt1;
  assign bus.p0_rvalid   = rvalid0_q;
  assign bus.p1_rvalid   = rvalid1_q;
  assign bus.p0_rdata    = rdata0_q;
  assign bus.p1_rdata    = rdata1_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter at RD_LAT 1 and 3
module tb_dmem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clock    = 1'b0;
  logic rst_n    = 1'b1;
  logic mem_init = 1'b1;
  always #5 clock = ~clock;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // shared requester drive, observed outputs per instance [inst][port]
  logic          p_req   [2];
  logic          p_we    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  logic          o_gnt   [2][2];
  logic          o_rv    [2][2];
  logic [DW-1:0] o_rd    [2][2];
  logic          o_wren  [2];
  logic [AW-1:0] o_maddr [2];
  logic [DW-1:0] o_mdata [2];

  function automatic logic [DW-1:0] init_val(int a);
    if (a == 16) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 ^ (a * 32'h0001_0203);
  endfunction

  function automatic int lat(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = (g == 0) ? 1 : 3;
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [DW-1:0] mem [64];
    logic [DW-1:0] qp  [L];

    assign bus.p0_req   = p_req[0];
    assign bus.p0_we    = p_we[0];
    assign bus.p0_addr  = p_addr[0];
    assign bus.p0_wdata = p_wdata[0];
    assign bus.p1_req   = p_req[1];
    assign bus.p1_we    = p_we[1];
    assign bus.p1_addr  = p_addr[1];
    assign bus.p1_wdata = p_wdata[1];
    assign bus.mem_q    = qp[L-1];

    // syncram with L cycles from registered command to q
    always @(posedge clock) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      end else if (bus.mem_wren) begin
        mem[bus.mem_address[5:0]] <= bus.mem_data;
      end
      qp[0] <= mem[bus.mem_address[5:0]];
      for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
    end

    assign o_gnt[g][0] = bus.p0_gnt;
    assign o_gnt[g][1] = bus.p1_gnt;
    assign o_rv[g][0]  = bus.p0_rvalid;
    assign o_rv[g][1]  = bus.p1_rvalid;
    assign o_rd[g][0]  = bus.p0_rdata;
    assign o_rd[g][1]  = bus.p1_rdata;
    assign o_wren[g]   = bus.mem_wren;
    assign o_maddr[g]  = bus.mem_address;
    assign o_mdata[g]  = bus.mem_data;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) dut (
      .clock (clock),
      .reset (rst_n),
      .bus   (bus)
    );
  end

  typedef struct {
    int            cyc;
    int            gp;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] data;
  } rd_t;

  gnt_t gq     [$];
  rd_t  rq_exp [$];

  // reference model state
  int            rr_m = 0;
  logic [DW-1:0] mmem [64];
  bit            won    [2];
  bit            stream [2];
  int            mode = 0;
  bit            r_act  [2];
  bit            r_we   [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wd   [2];

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      p_req[p]   = r_act[p];
      p_we[p]    = r_we[p];
      p_addr[p]  = r_addr[p];
      p_wdata[p] = r_wd[p];
    end
  endtask

  task automatic model();
    int   gp;
    gnt_t e;
    rd_t  r;
    gp = -1;
    if (r_act[0] && r_act[1]) gp = rr_m;
    else if (r_act[0]) gp = 0;
    else if (r_act[1]) gp = 1;
    won[0]  = (gp == 0);
    won[1]  = (gp == 1);
    e.cyc   = cyc;
    e.gp    = gp;
    e.we    = 1'b0;
    e.addr  = '0;
    e.wdata = '0;
    if (gp >= 0) begin
      e.we    = r_we[gp];
      e.addr  = r_addr[gp];
      e.wdata = r_wd[gp];
      rr_m    = 1 - gp;
      if (e.we) begin
        mmem[e.addr[5:0]] = e.wdata;
      end else begin
        r.cyc  = cyc;
        r.port = gp;
        r.data = mmem[e.addr[5:0]];
        rq_exp.push_back(r);
      end
    end
    gq.push_back(e);
  endtask

  task automatic set_req(int p, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd);
    r_act[p]  = 1'b1;
    r_we[p]   = we;
    r_addr[p] = addr;
    r_wd[p]   = wd;
    won[p]    = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (won[p]) begin
        r_act[p] = 1'b0;
        if (mode == 2 && stream[p]) begin
          r_act[p]  = 1'b1;
          r_we[p]   = 1'b0;
          r_addr[p] = r_addr[p] + 1'b1;
        end
      end else if (mode == 1 && r_act[p] && $urandom_range(0, 9) == 0) begin
        r_act[p] = 1'b0;
      end
      if (mode == 1 && !r_act[p] && $urandom_range(0, 2) != 0) begin
        r_act[p]  = 1'b1;
        r_we[p]   = ($urandom_range(0, 3) == 0);
        r_addr[p] = AW'($urandom_range(0, 15));
        r_wd[p]   = $urandom;
      end
    end
    drive();
    model();
  endtask

  task automatic do_reset(int n);
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    drive();
    gq.delete();
    rq_exp.delete();
    rr_m   = 0;
    won[0] = 1'b0;
    won[1] = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    rst_n = 1'b1;
    drive();
    model();
  endtask

  // monitor: compares DUT outputs against the scoreboard queues
  gnt_t          pw;
  bit            pw_v = 1'b0;
  int            ri [2];
  logic [DW-1:0] last_rd [2][2];

  always @(negedge clock) begin
    gnt_t e;
    rd_t  r;
    bit   ew;
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (o_gnt[g][0] !== 1'b0 || o_gnt[g][1] !== 1'b0 || o_rv[g][0] !== 1'b0 ||
            o_rv[g][1] !== 1'b0 || o_rd[g][0] !== '0 || o_rd[g][1] !== '0 ||
            o_wren[g] !== 1'b0 || o_maddr[g] !== '0 || o_mdata[g] !== '0) begin
          errors++;
          $display("FAIL reset_state inst%0d: gnt %b%b rvalid %b%b rdata %h %h wren %b addr %h data %h, want all 0",
                   g, o_gnt[g][1], o_gnt[g][0], o_rv[g][1], o_rv[g][0], o_rd[g][0], o_rd[g][1],
                   o_wren[g], o_maddr[g], o_mdata[g]);
        end
        ri[g] = 0;
        last_rd[g][0] = '0;
        last_rd[g][1] = '0;
      end
      pw_v = 1'b0;
    end else if (gq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL gnt_queue: no expectation at cycle %0d, want one per cycle", cyc);
    end else begin
      e = gq.pop_front();
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (o_gnt[g][0] !== (e.gp == 0) || o_gnt[g][1] !== (e.gp == 1)) begin
          errors++;
          $display("FAIL gnt inst%0d cycle %0d: got p0 %b p1 %b, want granted port %0d",
                   g, cyc, o_gnt[g][0], o_gnt[g][1], e.gp);
        end
        ew = pw_v && pw.gp >= 0 && pw.we;
        checks++;
        if (o_wren[g] !== ew) begin
          errors++;
          $display("FAIL mem_wren inst%0d cycle %0d: got %b, want %b", g, cyc, o_wren[g], ew);
        end
        if (pw_v && pw.gp >= 0) begin
          checks++;
          if (o_maddr[g] !== pw.addr || (pw.we && o_mdata[g] !== pw.wdata)) begin
            errors++;
            $display("FAIL mem_cmd inst%0d cycle %0d: got addr %h data %h, want addr %h data %h",
                     g, cyc, o_maddr[g], o_mdata[g], pw.addr, pw.wdata);
          end
        end
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (o_rv[g][p]) begin
            if (ri[g] >= rq_exp.size()) begin
              errors++;
              $display("FAIL spurious_rvalid inst%0d port%0d cycle %0d: got rvalid 1, want 0", g, p, cyc);
            end else begin
              r = rq_exp[ri[g]];
              ri[g]++;
              if (r.port != p || r.data !== o_rd[g][p] || cyc != r.cyc + 2 + lat(g)) begin
                errors++;
                $display("FAIL rvalid inst%0d: got port %0d data %h cycle %0d, want port %0d data %h cycle %0d",
                         g, p, o_rd[g][p], cyc, r.port, r.data, r.cyc + 2 + lat(g));
              end
            end
            last_rd[g][p] = o_rd[g][p];
          end else if (o_rd[g][p] !== last_rd[g][p]) begin
            errors++;
            $display("FAIL rdata_hold inst%0d port%0d cycle %0d: got %h, want %h",
                     g, p, cyc, o_rd[g][p], last_rd[g][p]);
          end
        end
        if (ri[g] < rq_exp.size() && cyc > rq_exp[ri[g]].cyc + 2 + lat(g)) begin
          checks++;
          errors++;
          $display("FAIL rvalid_missing inst%0d: got none by cycle %0d, want port %0d data %h at cycle %0d",
                   g, cyc, rq_exp[ri[g]].port, rq_exp[ri[g]].data, rq_exp[ri[g]].cyc + 2 + lat(g));
          ri[g]++;
        end
      end
      pw   = e;
      pw_v = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mmem[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      r_act[p]  = 1'b0;
      r_we[p]   = 1'b0;
      r_addr[p] = '0;
      r_wd[p]   = '0;
      won[p]    = 1'b0;
      stream[p] = 1'b0;
    end
    drive();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 mem_init = 1'b0;
    do_reset(1);

    // p0 read of 0x010
    set_req(0, 1'b0, 12'h010, '0);
    step();
    repeat (5) step();

    // p1 write then p0 read of the same address the next cycle
    set_req(1, 1'b1, 12'h005, 32'h0000_0123);
    step();
    set_req(0, 1'b0, 12'h005, '0);
    step();
    repeat (5) step();

    // p0 request abandoned while p1 holds the grant
    set_req(1, 1'b1, 12'h021, 32'h0000_0077);
    set_req(0, 1'b1, 12'h020, 32'h0000_0BAD);
    step();
    r_act[0] = 1'b0;
    step();
    repeat (2) step();

    // both ports streaming reads: strict alternation
    mode = 2;
    stream[0] = 1'b1;
    stream[1] = 1'b1;
    set_req(0, 1'b0, 12'h030, '0);
    set_req(1, 1'b0, 12'h038, '0);
    repeat (6) step();
    stream[0] = 1'b0;
    stream[1] = 1'b0;
    r_act[0]  = 1'b0;
    r_act[1]  = 1'b0;
    mode = 0;
    step();

    // aborted write must have left 0x020 untouched
    set_req(0, 1'b0, 12'h020, '0);
    step();
    repeat (6) step();

    // four back-to-back p0 reads 0x000..0x003
    mode = 2;
    stream[0] = 1'b1;
    set_req(0, 1'b0, 12'h000, '0);
    repeat (4) step();
    stream[0] = 1'b0;
    mode = 0;
    repeat (8) step();

    // reset while a read is in flight, then simultaneous requests
    set_req(0, 1'b0, 12'h010, '0);
    step();
    step();
    set_req(0, 1'b0, 12'h011, '0);
    set_req(1, 1'b0, 12'h012, '0);
    do_reset(1);
    repeat (8) step();

    // randomized traffic
    mode = 1;
    repeat (3000) step();
    mode = 0;
    r_act[0] = 1'b0;
    r_act[1] = 1'b0;
    repeat (10) step();
    @(negedge clock);

    for (int g = 0; g < 2; g++) begin
      checks++;
      if (ri[g] != rq_exp.size()) begin
        errors++;
        $display("FAIL drain inst%0d: got %0d read responses, want %0d", g, ri[g], rq_exp.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
